uart_rx_path: RTL and testbench

UART_RX_PATH -- requirements
Module: uart_rx_path

---
 rtl/uart_rx_path.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_path.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_path.sv
// 16x-oversampled 8N1 UART receiver feeding a receive FIFO with registered read data.
// Define UART_RX_BREAK_EN to enable break detection on break_det; otherwise it is tied low.
module uart_rx_path #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                          uart_clk,
  input  logic                          rst,
  input  logic                          baud_tick,
  input  logic                          rx_serial,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          rx_active,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          break_det
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                state, state_nxt;
  logic [3:0]            tick_cnt, tick_cnt_nxt;
  logic [2:0]            bit_cnt, bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic                  push, bad_stop;
  logic                  rx_meta_p0, rx_sync_p1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic                  pop, wr;

  // stage p0/p1: line synchronizer, idles high so reset cannot fake a start bit
  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      rx_meta_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_meta_p0 <= rx_serial;
      rx_sync_p1 <= rx_meta_p0;
    end
  end

  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
    end
  end

  always_ff @(posedge uart_clk) begin
    shreg <= shreg_nxt;
  end

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    push         = 1'b0;
    bad_stop     = 1'b0;
    if (baud_tick) begin
      case (state)
        IDLE: begin
          if (!rx_sync_p1) begin
            state_nxt    = START;
            tick_cnt_nxt = '0;
          end
        end
        START: begin
          if (tick_cnt == 4'd7) begin
            tick_cnt_nxt = '0;
            bit_cnt_nxt  = '0;
            state_nxt    = rx_sync_p1 ? IDLE : DATA;
          end else begin
            tick_cnt_nxt = tick_cnt + 4'd1;
          end
        end
        DATA: begin
          if (tick_cnt == 4'd15) begin
            tick_cnt_nxt = '0;
            shreg_nxt    = {rx_sync_p1, shreg[DATA_WIDTH-1:1]};
            if (bit_cnt == 3'(DATA_WIDTH - 1))
              state_nxt = STOP;
            else
              bit_cnt_nxt = bit_cnt + 3'd1;
          end else begin
            tick_cnt_nxt = tick_cnt + 4'd1;
          end
        end
        STOP: begin
          if (tick_cnt == 4'd15) begin
            tick_cnt_nxt = '0;
            if (rx_sync_p1) begin
              push      = 1'b1;
              state_nxt = IDLE;
            end else begin
              bad_stop  = 1'b1;
              state_nxt = WAIT_HIGH;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 4'd1;
          end
        end
        WAIT_HIGH: ;
        default: state_nxt = IDLE;
      endcase
    end
    // a held-low line after a bad stop must not be mistaken for a new start bit
    if (state == WAIT_HIGH && rx_sync_p1)
      state_nxt = IDLE;
  end

  assign rx_active = (state != IDLE);

  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= bad_stop;
      overrun   <= push && rx_full && !pop;
    end
  end

`ifdef UART_RX_BREAK_EN
  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst)
      break_det <= 1'b0;
    else
      break_det <= bad_stop && (shreg == '0);
  end
`else
  assign break_det = 1'b0;
`endif

  assign rx_empty = (rx_level == '0);
  assign rx_full  = (rx_level == LW'(FIFO_DEPTH));
  assign pop      = rd_en && !rx_empty;
  // a pop frees the slot this cycle, so a push into a full FIFO still lands
  assign wr       = push && (!rx_full || pop);

  always_ff @(posedge uart_clk) begin
    if (wr)
      mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge uart_clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_level <= '0;
      rd_data  <= '0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({wr, pop})
        2'b10:   rx_level <= rx_level + LW'(1);
        2'b01:   rx_level <= rx_level - LW'(1);
        default: rx_level <= rx_level;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_path.sv
// Directed bench for uart_rx_path: table of frames/pops plus overrun, full-coincident, glitch and reset sequences.
`timescale 1ns/1ps
module tb_uart_rx_path;
  localparam int DEPTH = 8;
`ifdef UART_RX_BREAK_EN
  localparam int BRK_ON = 1;
`else
  localparam int BRK_ON = 0;
`endif

  logic       uart_clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx_serial = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       rx_empty, rx_full, rx_active, frame_err, overrun, break_det;
  logic [3:0] rx_level;

  int total = 0;
  int bad = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int brk_cnt = 0;
  int brk_orphan = 0;
  int act_cnt = 0;

  typedef struct {
    bit         is_pop;
    logic [7:0] data;
    bit         stop;
    int         lvl;
    logic [7:0] rd;
    int         ferr;
    int         brk;
  } vec_t;
  vec_t tbl[9];

  uart_rx_path #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
    .uart_clk (uart_clk),
    .rst      (rst),
    .baud_tick(baud_tick),
    .rx_serial(rx_serial),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rx_empty (rx_empty),
    .rx_full  (rx_full),
    .rx_level (rx_level),
    .rx_active(rx_active),
    .frame_err(frame_err),
    .overrun  (overrun),
    .break_det(break_det)
  );

  always #5 uart_clk = ~uart_clk;

  // tick every other clock, changing on the falling edge so it is stable at rising edges
  always @(negedge uart_clk) begin
    baud_tick <= ~baud_tick;
    if (!rst) begin
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (break_det) brk_cnt++;
      if (break_det && !frame_err) brk_orphan++;
      if (rx_active) act_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick();
    do @(posedge uart_clk); while (!baud_tick);
    #1;
  endtask

  // start, 8 data bits LSB first, stop; optionally pops exactly on the push edge
  task automatic send_byte(input logic [7:0] d, input bit stop, input bit pop_at_push);
    wait_tick();
    rx_serial = 1'b0;
    repeat (16) wait_tick();
    for (int i = 0; i < 8; i++) begin
      rx_serial = d[i];
      repeat (16) wait_tick();
    end
    rx_serial = stop;
    if (pop_at_push) begin
      repeat (9) wait_tick();
      @(posedge uart_clk);
      #1 rd_en = 1'b1;
      @(posedge uart_clk);
      #1 rd_en = 1'b0;
      repeat (6) wait_tick();
    end else begin
      repeat (16) wait_tick();
    end
    rx_serial = 1'b1;
    repeat (6) wait_tick();
  endtask

  task automatic pop_byte();
    rd_en = 1'b1;
    @(posedge uart_clk);
    #1 rd_en = 1'b0;
    @(negedge uart_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, rx_empty, 1);
    check({tag, "_full"}, rx_full, 0);
    check({tag, "_active"}, rx_active, 0);
    check({tag, "_level"}, rx_level, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_break"}, break_det, 0);
  endtask

  initial begin
    int act0;
    tbl[0] = '{1'b0, 8'hA5, 1'b1, 1, 8'h00, 0, 0};
    tbl[1] = '{1'b1, 8'h00, 1'b1, 0, 8'hA5, 0, 0};
    tbl[2] = '{1'b0, 8'h3C, 1'b0, 0, 8'h00, 1, 0};
    tbl[3] = '{1'b0, 8'h11, 1'b1, 1, 8'h00, 1, 0};
    tbl[4] = '{1'b1, 8'h00, 1'b1, 0, 8'h11, 1, 0};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 0, 8'h00, 2, BRK_ON};
    tbl[6] = '{1'b0, 8'hFF, 1'b1, 1, 8'h00, 2, BRK_ON};
    tbl[7] = '{1'b1, 8'h00, 1'b1, 0, 8'hFF, 2, BRK_ON};
    tbl[8] = '{1'b1, 8'h00, 1'b1, 0, 8'hFF, 2, BRK_ON};

    repeat (3) @(posedge uart_clk);
    @(negedge uart_clk);
    check_reset_outputs("rst0");
    @(posedge uart_clk);
    #1 rst = 1'b0;
    repeat (4) wait_tick();

    for (int r = 0; r < 9; r++) begin
      if (tbl[r].is_pop) begin
        pop_byte();
        check($sformatf("row%0d_rd_data", r), rd_data, tbl[r].rd);
      end else begin
        send_byte(tbl[r].data, tbl[r].stop, 1'b0);
        @(negedge uart_clk);
      end
      check($sformatf("row%0d_level", r), rx_level, tbl[r].lvl);
      check($sformatf("row%0d_empty", r), rx_empty, (tbl[r].lvl == 0));
      check($sformatf("row%0d_frame_err_cnt", r), ferr_cnt, tbl[r].ferr);
      check($sformatf("row%0d_break_cnt", r), brk_cnt, tbl[r].brk);
      check($sformatf("row%0d_active", r), rx_active, 0);
    end
    check("break_with_frame_err", brk_orphan, 0);

    // 4-tick glitch: enters START, rejected at the mid-bit sample
    act0 = act_cnt;
    wait_tick();
    rx_serial = 1'b0;
    repeat (4) wait_tick();
    rx_serial = 1'b1;
    repeat (20) wait_tick();
    @(negedge uart_clk);
    check("glitch_seen_active", (act_cnt > act0), 1);
    check("glitch_active", rx_active, 0);
    check("glitch_level", rx_level, 0);
    check("glitch_frame_err", ferr_cnt, 2);
    check("glitch_overrun", ovr_cnt, 0);

    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1, 1'b0);
    @(negedge uart_clk);
    check("fill_full", rx_full, 1);
    check("fill_level", rx_level, 8);
    check("fill_overrun", ovr_cnt, 0);
    send_byte(8'h09, 1'b1, 1'b0);
    @(negedge uart_clk);
    check("ovr_count", ovr_cnt, 1);
    check("ovr_level", rx_level, 8);
    check("ovr_full", rx_full, 1);
    for (int i = 1; i <= 8; i++) begin
      pop_byte();
      check($sformatf("ovr_rd%0d", i), rd_data, i);
    end
    check("ovr_drained", rx_empty, 1);

    for (int i = 0; i < 8; i++) send_byte(8'h21 + 8'(i), 1'b1, 1'b0);
    @(negedge uart_clk);
    check("coin_pre_full", rx_full, 1);
    send_byte(8'h29, 1'b1, 1'b1);
    @(negedge uart_clk);
    check("coin_rd", rd_data, 8'h21);
    check("coin_level", rx_level, 8);
    check("coin_overrun", ovr_cnt, 1);
    for (int i = 2; i <= 9; i++) begin
      pop_byte();
      check($sformatf("coin_rd%0d", i), rd_data, 8'h20 + 8'(i));
    end
    check("coin_drained", rx_level, 0);

    send_byte(8'h77, 1'b1, 1'b0);
    @(negedge uart_clk);
    check("pre_rst_level", rx_level, 1);
    wait_tick();
    rx_serial = 1'b0;
    repeat (16) wait_tick();
    rx_serial = 1'b1;
    repeat (16) wait_tick();
    rx_serial = 1'b0;
    repeat (5) wait_tick();
    check("midframe_active", rx_active, 1);
    rst = 1'b1;
    #2;
    check_reset_outputs("rst1");
    rx_serial = 1'b1;
    @(posedge uart_clk);
    @(posedge uart_clk);
    #1 rst = 1'b0;
    repeat (20) wait_tick();
    @(negedge uart_clk);
    check("post_rst_active", rx_active, 0);
    check("post_rst_level", rx_level, 0);
    send_byte(8'h5A, 1'b1, 1'b0);
    @(negedge uart_clk);
    check("post_rst_rx_level", rx_level, 1);
    pop_byte();
    check("post_rst_rd", rd_data, 8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
